// File: rtl/axis_tx_pkt_arbiter.sv
// ---------------------------------------------------------------------------
// axis_tx_pkt_arbiter
//
// Packet-aware two-source AXI-Stream arbiter for the shared PCIe SS TX port.
//   source 0 : MMIO read-completion stream (normally preferred)
//   source 1 : MSI-X interrupt stream (protected from starvation by aging)
//
// Once the first beat of a multi-beat packet is accepted, the grant stays
// with that source until its tlast beat is accepted. While both sources
// wait in IDLE, source 0 wins unless it has already completed MAX_HI_PKTS
// packets in a row while source 1 was waiting. In that case source 1 wins
// the next arbitration.
//
// Optional build macro:
//   AXIS_TX_ARB_OUTREG_EN - the output side comes from a 2-entry skid buffer.
//                           This adds one cycle of latency, and sN_tready
//                           means "the buffer has a free entry". When the
//                           macro is undefined, the arbiter is a
//                           zero-latency combinational pass-through.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   s0_* / s1_*            AXI-S sinks (tvalid/tready/tlast/tdata/tkeep/
//                          tuser_vendor)
//   m_*                    AXI-S source toward the host TX interface
//   stat_clr               one-cycle pulse that clears both packet counters
//   pkt_cnt0, pkt_cnt1     saturating per-source count of forwarded packets
//   busy                   high while a packet lock is held
// ---------------------------------------------------------------------------
module axis_tx_pkt_arbiter #(
    parameter int DATA_WIDTH  = 512,
    parameter int USER_WIDTH  = 10,
    parameter int MAX_HI_PKTS = 4
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    s0_tvalid,
    output logic                    s0_tready,
    input  logic                    s0_tlast,
    input  logic [DATA_WIDTH-1:0]   s0_tdata,
    input  logic [DATA_WIDTH/8-1:0] s0_tkeep,
    input  logic [USER_WIDTH-1:0]   s0_tuser_vendor,

    input  logic                    s1_tvalid,
    output logic                    s1_tready,
    input  logic                    s1_tlast,
    input  logic [DATA_WIDTH-1:0]   s1_tdata,
    input  logic [DATA_WIDTH/8-1:0] s1_tkeep,
    input  logic [USER_WIDTH-1:0]   s1_tuser_vendor,

    output logic                    m_tvalid,
    input  logic                    m_tready,
    output logic                    m_tlast,
    output logic [DATA_WIDTH-1:0]   m_tdata,
    output logic [DATA_WIDTH/8-1:0] m_tkeep,
    output logic [USER_WIDTH-1:0]   m_tuser_vendor,

    input  logic                    stat_clr,
    output logic [15:0]             pkt_cnt0,
    output logic [15:0]             pkt_cnt1,
    output logic                    busy
);

    localparam int         KEEP_WIDTH = DATA_WIDTH / 8;
    localparam logic [7:0] MAX_HI     = 8'(MAX_HI_PKTS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_t;

    state_t                  state_r;
    state_t                  state_nxt_s;
    logic [7:0]              hi_cnt_r;
    logic [15:0]             pkt_cnt0_r;
    logic [15:0]             pkt_cnt1_r;

    logic                    sel_en_s;     // a source is connected this cycle
    logic                    sel_src_s;    // 0 = source 0, 1 = source 1
    logic                    age_hit_s;
    logic                    sel_tvalid_s;
    logic                    sel_tlast_s;
    logic [DATA_WIDTH-1:0]   sel_tdata_s;
    logic [KEEP_WIDTH-1:0]   sel_tkeep_s;
    logic [USER_WIDTH-1:0]   sel_tuser_s;
    logic                    in_ready_s;   // ready offered to the selected source
    logic                    in_hs_s;
    logic                    done0_s;
    logic                    done1_s;

    // Source 1 has waited through MAX_HI_PKTS source-0 packets. A setting of 0 turns aging off.
    assign age_hit_s = (MAX_HI != 8'd0) && (hi_cnt_r == MAX_HI);

    // Pick the connected source: arbitrate in IDLE, hold the grant while locked.
    always_comb begin
        sel_en_s  = 1'b0;
        sel_src_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (s0_tvalid && s1_tvalid) begin
                    sel_en_s  = 1'b1;
                    sel_src_s = age_hit_s;
                end else if (s1_tvalid) begin
                    sel_en_s  = 1'b1;
                    sel_src_s = 1'b1;
                end else if (s0_tvalid) begin
                    sel_en_s  = 1'b1;
                    sel_src_s = 1'b0;
                end else begin
                    sel_en_s  = 1'b0;
                    sel_src_s = 1'b0;
                end
            end
            LOCK0: begin
                sel_en_s  = 1'b1;
                sel_src_s = 1'b0;
            end
            LOCK1: begin
                sel_en_s  = 1'b1;
                sel_src_s = 1'b1;
            end
            default: begin
                sel_en_s  = 1'b0;
                sel_src_s = 1'b0;
            end
        endcase
    end

    // Payload mux. Everything is zero when no source is connected.
    always_comb begin
        sel_tvalid_s = 1'b0;
        sel_tlast_s  = 1'b0;
        sel_tdata_s  = '0;
        sel_tkeep_s  = '0;
        sel_tuser_s  = '0;
        if (sel_en_s) begin
            if (sel_src_s) begin
                sel_tvalid_s = s1_tvalid;
                sel_tlast_s  = s1_tlast;
                sel_tdata_s  = s1_tdata;
                sel_tkeep_s  = s1_tkeep;
                sel_tuser_s  = s1_tuser_vendor;
            end else begin
                sel_tvalid_s = s0_tvalid;
                sel_tlast_s  = s0_tlast;
                sel_tdata_s  = s0_tdata;
                sel_tkeep_s  = s0_tkeep;
                sel_tuser_s  = s0_tuser_vendor;
            end
        end else begin
            sel_tvalid_s = 1'b0;
            sel_tlast_s  = 1'b0;
        end
    end

    assign s0_tready = sel_en_s && !sel_src_s && in_ready_s;
    assign s1_tready = sel_en_s &&  sel_src_s && in_ready_s;
    assign in_hs_s   = sel_tvalid_s && in_ready_s;
    assign done0_s   = in_hs_s && sel_tlast_s && !sel_src_s;
    assign done1_s   = in_hs_s && sel_tlast_s &&  sel_src_s;

`ifdef AXIS_TX_ARB_OUTREG_EN
    localparam int ENTRY_WIDTH = 1 + USER_WIDTH + KEEP_WIDTH + DATA_WIDTH;

    logic [ENTRY_WIDTH-1:0]  buf_mem_r [2];
    logic [1:0]              buf_cnt_r;
    logic [1:0]              buf_cnt_nxt_s;
    logic                    buf_wr_ptr_r;
    logic                    buf_rd_ptr_r;
    logic                    buf_ready_r;
    logic                    buf_pop_s;
    logic [ENTRY_WIDTH-1:0]  buf_head_s;

    assign in_ready_s = buf_ready_r && !rst;
    assign buf_pop_s  = (buf_cnt_r != 2'd0) && m_tready;

    // Occupancy after this cycle's push and pop.
    always_comb begin
        buf_cnt_nxt_s = buf_cnt_r;
        if (in_hs_s && !buf_pop_s) begin
            buf_cnt_nxt_s = buf_cnt_r + 2'd1;
        end else if (!in_hs_s && buf_pop_s) begin
            buf_cnt_nxt_s = buf_cnt_r - 2'd1;
        end else begin
            buf_cnt_nxt_s = buf_cnt_r;
        end
    end

    // Skid buffer storage, pointers and the registered free-entry flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_mem_r[0] <= '0;
            buf_mem_r[1] <= '0;
            buf_cnt_r    <= 2'd0;
            buf_wr_ptr_r <= 1'b0;
            buf_rd_ptr_r <= 1'b0;
            buf_ready_r  <= 1'b1;
        end else begin
            if (in_hs_s) begin
                buf_mem_r[buf_wr_ptr_r] <= {sel_tlast_s, sel_tuser_s, sel_tkeep_s, sel_tdata_s};
                buf_wr_ptr_r            <= ~buf_wr_ptr_r;
            end
            if (buf_pop_s) begin
                buf_rd_ptr_r <= ~buf_rd_ptr_r;
            end
            buf_cnt_r   <= buf_cnt_nxt_s;
            buf_ready_r <= (buf_cnt_nxt_s != 2'd2);
        end
    end

    // Present the head entry. Zero is shown while the buffer is empty.
    always_comb begin
        buf_head_s = '0;
        if (buf_cnt_r != 2'd0) begin
            buf_head_s = buf_mem_r[buf_rd_ptr_r];
        end else begin
            buf_head_s = '0;
        end
    end

    assign m_tvalid = (buf_cnt_r != 2'd0) && !rst;
    assign {m_tlast, m_tuser_vendor, m_tkeep, m_tdata} = buf_head_s;
`else
    assign in_ready_s     = m_tready && !rst;
    assign m_tvalid       = sel_tvalid_s && !rst;
    assign m_tlast        = sel_tlast_s;
    assign m_tdata        = sel_tdata_s;
    assign m_tkeep        = sel_tkeep_s;
    assign m_tuser_vendor = sel_tuser_s;
`endif

    // Next lock state: lock on a non-last first beat, release on an accepted tlast.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_hs_s && !sel_tlast_s) begin
                    state_nxt_s = sel_src_s ? LOCK1 : LOCK0;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            LOCK0, LOCK1: begin
                if (in_hs_s && sel_tlast_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Lock state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Aging counter: counts source-0 packets that completed while source 1 waited.
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_cnt_r <= 8'd0;
        end else if (done1_s) begin
            hi_cnt_r <= 8'd0;
        end else if (done0_s && s1_tvalid && (hi_cnt_r < MAX_HI)) begin
            hi_cnt_r <= hi_cnt_r + 8'd1;
        end else begin
            hi_cnt_r <= hi_cnt_r;
        end
    end

    // Saturating per-source packet counters. A clear wins over a same-cycle increment.
    always_ff @(posedge clk) begin
        if (rst || stat_clr) begin
            pkt_cnt0_r <= 16'd0;
            pkt_cnt1_r <= 16'd0;
        end else begin
            if (done0_s && (pkt_cnt0_r != 16'hFFFF)) begin
                pkt_cnt0_r <= pkt_cnt0_r + 16'd1;
            end
            if (done1_s && (pkt_cnt1_r != 16'hFFFF)) begin
                pkt_cnt1_r <= pkt_cnt1_r + 16'd1;
            end
        end
    end

    assign pkt_cnt0 = pkt_cnt0_r;
    assign pkt_cnt1 = pkt_cnt1_r;
    assign busy     = (state_r != IDLE);

endmodule

// File: tb/tb_axis_tx_pkt_arbiter.sv
// ---------------------------------------------------------------------------
// tb_axis_tx_pkt_arbiter
//
// Directed bench for axis_tx_pkt_arbiter in its pass-through build. The main
// instance uses MAX_HI_PKTS=4. A second instance with MAX_HI_PKTS=0 shares
// the same inputs and is used to check strict priority.
//
// Inputs change 2 ns after each rising edge. Outputs are sampled 1 ns later,
// which is well before the next rising edge.
// ---------------------------------------------------------------------------
module tb_axis_tx_pkt_arbiter;

    localparam int DW = 512;
    localparam int UW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          s0_tvalid, s0_tlast, s1_tvalid, s1_tlast;
    logic [DW-1:0] s0_tdata, s1_tdata;
    logic [DW/8-1:0] s0_tkeep, s1_tkeep;
    logic [UW-1:0] s0_tuser, s1_tuser;
    logic          m_tready, stat_clr;

    logic          s0_tready, s1_tready, m_tvalid, m_tlast, busy;
    logic [DW-1:0] m_tdata;
    logic [DW/8-1:0] m_tkeep;
    logic [UW-1:0] m_tuser;
    logic [15:0]   pkt_cnt0, pkt_cnt1;

    logic          sp_s0_tready, sp_s1_tready, sp_m_tvalid, sp_m_tlast, sp_busy;
    logic [DW-1:0] sp_m_tdata;
    logic [DW/8-1:0] sp_m_tkeep;
    logic [UW-1:0] sp_m_tuser;
    logic [15:0]   sp_pkt_cnt0, sp_pkt_cnt1;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    axis_tx_pkt_arbiter #(.DATA_WIDTH(DW), .USER_WIDTH(UW), .MAX_HI_PKTS(4)) dut (
        .clk(clk), .rst(rst),
        .s0_tvalid(s0_tvalid), .s0_tready(s0_tready), .s0_tlast(s0_tlast),
        .s0_tdata(s0_tdata), .s0_tkeep(s0_tkeep), .s0_tuser_vendor(s0_tuser),
        .s1_tvalid(s1_tvalid), .s1_tready(s1_tready), .s1_tlast(s1_tlast),
        .s1_tdata(s1_tdata), .s1_tkeep(s1_tkeep), .s1_tuser_vendor(s1_tuser),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
        .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tuser_vendor(m_tuser),
        .stat_clr(stat_clr), .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1), .busy(busy)
    );

    axis_tx_pkt_arbiter #(.DATA_WIDTH(DW), .USER_WIDTH(UW), .MAX_HI_PKTS(0)) dut_sp (
        .clk(clk), .rst(rst),
        .s0_tvalid(s0_tvalid), .s0_tready(sp_s0_tready), .s0_tlast(s0_tlast),
        .s0_tdata(s0_tdata), .s0_tkeep(s0_tkeep), .s0_tuser_vendor(s0_tuser),
        .s1_tvalid(s1_tvalid), .s1_tready(sp_s1_tready), .s1_tlast(s1_tlast),
        .s1_tdata(s1_tdata), .s1_tkeep(s1_tkeep), .s1_tuser_vendor(s1_tuser),
        .m_tvalid(sp_m_tvalid), .m_tready(m_tready), .m_tlast(sp_m_tlast),
        .m_tdata(sp_m_tdata), .m_tkeep(sp_m_tkeep), .m_tuser_vendor(sp_m_tuser),
        .stat_clr(stat_clr), .pkt_cnt0(sp_pkt_cnt0), .pkt_cnt1(sp_pkt_cnt1), .busy(sp_busy)
    );

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drv0(input logic v, input logic last, input logic [31:0] d);
        s0_tvalid = v;
        s0_tlast  = last;
        s0_tdata  = DW'(d);
    endtask

    task automatic drv1(input logic v, input logic last, input logic [31:0] d);
        s1_tvalid = v;
        s1_tlast  = last;
        s1_tdata  = DW'(d);
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b1;
        drv0(1'b0, 1'b0, 32'h0);
        drv1(1'b0, 1'b0, 32'h0);
        tick();
        rst = 1'b0;
    endtask

    logic [9:0] exp_src;

    initial begin
        rst      = 1'b1;
        m_tready = 1'b1;
        stat_clr = 1'b0;
        s0_tkeep = '0;
        s1_tkeep = '0;
        s0_tuser = '0;
        s1_tuser = '0;
        drv0(1'b1, 1'b1, 32'h1);
        drv1(1'b1, 1'b1, 32'h2);

        // Reset forces every ready and m_tvalid low, even with valid sources.
        tick();
        chk("rst_s0_tready", s0_tready, 1'b0);
        chk("rst_s1_tready", s1_tready, 1'b0);
        chk("rst_m_tvalid", m_tvalid, 1'b0);
        tick();
        rst = 1'b0;
        drv0(1'b0, 1'b0, 32'h0);
        drv1(1'b0, 1'b0, 32'h0);
        #1;
        chk("reset_busy", busy, 1'b0);
        chk("reset_cnt0", pkt_cnt0, 16'd0);
        chk("reset_cnt1", pkt_cnt1, 16'd0);
        chk("idle_m_tvalid", m_tvalid, 1'b0);
        chk("idle_m_tdata", m_tdata, '0);
        chk("idle_m_tkeep", m_tkeep, '0);

        // Test 1: three single-beat source-0 packets, back to back.
        s0_tkeep = '1;
        s0_tuser = 10'h2A;
        for (int i = 0; i < 3; i++) begin
            tick();
            drv0(1'b1, 1'b1, 32'hA0 + 32'(i));
            #1;
            chk("t1_m_tvalid", m_tvalid, 1'b1);
            chk("t1_m_tdata", m_tdata, DW'(32'hA0 + 32'(i)));
            chk("t1_s0_tready", s0_tready, 1'b1);
            chk("t1_m_tlast", m_tlast, 1'b1);
        end
        chk("t1_m_tkeep", m_tkeep, {(DW/8){1'b1}});
        chk("t1_m_tuser", m_tuser, 10'h2A);
        tick();
        drv0(1'b0, 1'b0, 32'h0);
        #1;
        chk("t1_cnt0", pkt_cnt0, 16'd3);
        chk("t1_cnt1", pkt_cnt1, 16'd0);
        chk("t1_m_tvalid_off", m_tvalid, 1'b0);

        // Test 2: 4-beat source-0 packet; source 1 becomes valid on beat 2 and must wait.
        for (int b = 1; b <= 4; b++) begin
            tick();
            drv0(1'b1, (b == 4), 32'hB0 + 32'(b));
            drv1((b >= 2), 1'b1, 32'hC1);
            #1;
            chk("t2_m_tdata", m_tdata, DW'(32'hB0 + 32'(b)));
            chk("t2_m_tlast", m_tlast, (b == 4));
            chk("t2_s1_tready", s1_tready, 1'b0);
            chk("t2_busy", busy, (b >= 2));
        end
        tick();
        drv0(1'b0, 1'b0, 32'h0);
        #1;
        chk("t2_s1_m_tdata", m_tdata, DW'(32'hC1));
        chk("t2_s1_tready_go", s1_tready, 1'b1);
        chk("t2_busy_after", busy, 1'b0);
        tick();
        drv1(1'b0, 1'b0, 32'h0);
        #1;
        chk("t2_cnt0", pkt_cnt0, 16'd4);
        chk("t2_cnt1", pkt_cnt1, 16'd1);

        // Test 3: aging with MAX_HI_PKTS=4 gives the order 0,0,0,0,1,0,0,0,0,1.
        exp_src = 10'b10_0001_0000;
        for (int i = 0; i < 10; i++) begin
            tick();
            drv0(1'b1, 1'b1, 32'h50);
            drv1(1'b1, 1'b1, 32'h51);
            #1;
            chk("t3_m_tdata", m_tdata, exp_src[i] ? DW'(32'h51) : DW'(32'h50));
            chk("t3_s1_tready", s1_tready, exp_src[i]);
            chk("t3_s0_tready", s0_tready, !exp_src[i]);
        end
        tick();
        drv0(1'b0, 1'b0, 32'h0);
        drv1(1'b0, 1'b0, 32'h0);
        #1;
        chk("t3_cnt0", pkt_cnt0, 16'd12);
        chk("t3_cnt1", pkt_cnt1, 16'd3);

        // Test 4: strict priority (MAX_HI_PKTS=0); source 1 waits until s0_tvalid drops.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            tick();
            drv0(1'b1, 1'b1, 32'h50);
            drv1(1'b1, 1'b1, 32'h51);
            #1;
            chk("t4_sp_m_tdata", sp_m_tdata, DW'(32'h50));
            chk("t4_sp_s1_tready", sp_s1_tready, 1'b0);
        end
        tick();
        drv0(1'b0, 1'b0, 32'h0);
        #1;
        chk("t4_sp_s1_m_tdata", sp_m_tdata, DW'(32'h51));
        chk("t4_sp_s1_tready_go", sp_s1_tready, 1'b1);

        // Test 5: m_tready stalls and a source-0 valid gap inside a locked packet.
        do_reset();
        tick();
        m_tready = 1'b1;
        drv0(1'b1, 1'b0, 32'h61);
        drv1(1'b1, 1'b1, 32'h51);
        #1;
        chk("t5_c1_m_tdata", m_tdata, DW'(32'h61));
        chk("t5_c1_s0_tready", s0_tready, 1'b1);
        tick();
        m_tready = 1'b0;
        drv0(1'b1, 1'b0, 32'h62);
        #1;
        chk("t5_c2_m_tvalid", m_tvalid, 1'b1);
        chk("t5_c2_s0_tready", s0_tready, 1'b0);
        chk("t5_c2_m_tdata", m_tdata, DW'(32'h62));
        chk("t5_c2_busy", busy, 1'b1);
        tick();
        m_tready = 1'b1;
        drv0(1'b0, 1'b0, 32'h0);
        #1;
        chk("t5_c3_m_tvalid", m_tvalid, 1'b0);
        chk("t5_c3_s1_tready", s1_tready, 1'b0);
        chk("t5_c3_busy", busy, 1'b1);
        tick();
        drv0(1'b1, 1'b0, 32'h62);
        #1;
        chk("t5_c4_m_tdata", m_tdata, DW'(32'h62));
        chk("t5_c4_s0_tready", s0_tready, 1'b1);
        tick();
        m_tready = 1'b0;
        drv0(1'b1, 1'b1, 32'h63);
        #1;
        chk("t5_c5_s0_tready", s0_tready, 1'b0);
        chk("t5_c5_m_tvalid", m_tvalid, 1'b1);
        tick();
        m_tready = 1'b1;
        #1;
        chk("t5_c6_m_tlast", m_tlast, 1'b1);
        chk("t5_c6_m_tdata", m_tdata, DW'(32'h63));
        chk("t5_c6_s0_tready", s0_tready, 1'b1);
        tick();
        drv0(1'b0, 1'b0, 32'h0);
        #1;
        chk("t5_c7_m_tdata", m_tdata, DW'(32'h51));
        chk("t5_c7_s1_tready", s1_tready, 1'b1);
        chk("t5_c7_busy", busy, 1'b0);
        chk("t5_c7_cnt0", pkt_cnt0, 16'd1);

        // Test 6: stat_clr in the same cycle as a tlast handshake.
        tick();
        drv1(1'b0, 1'b0, 32'h0);
        drv0(1'b1, 1'b1, 32'h70);
        stat_clr = 1'b1;
        #1;
        chk("t6_cnt0_before", pkt_cnt0, 16'd1);
        chk("t6_cnt1_before", pkt_cnt1, 16'd1);
        chk("t6_s0_tready", s0_tready, 1'b1);
        tick();
        stat_clr = 1'b0;
        drv0(1'b0, 1'b0, 32'h0);
        #1;
        chk("t6_cnt0_clr", pkt_cnt0, 16'd0);
        chk("t6_cnt1_clr", pkt_cnt1, 16'd0);

        // Test 7: reset while locked on source 1.
        tick();
        drv1(1'b1, 1'b0, 32'h80);
        #1;
        chk("t7_s1_tready", s1_tready, 1'b1);
        tick();
        drv1(1'b1, 1'b0, 32'h81);
        #1;
        chk("t7_busy_lock1", busy, 1'b1);
        tick();
        rst = 1'b1;
        #1;
        chk("t7_rst_s1_tready", s1_tready, 1'b0);
        chk("t7_rst_m_tvalid", m_tvalid, 1'b0);
        tick();
        rst = 1'b0;
        drv1(1'b0, 1'b0, 32'h0);
        #1;
        chk("t7_busy_after", busy, 1'b0);
        chk("t7_m_tvalid_after", m_tvalid, 1'b0);
        tick();
        drv0(1'b1, 1'b1, 32'h90);
        #1;
        chk("t7_idle_s0_tready", s0_tready, 1'b1);

        // Test 8: 65540 single-beat source-1 packets saturate pkt_cnt1.
        tick();
        drv0(1'b0, 1'b0, 32'h0);
        drv1(1'b1, 1'b1, 32'hD0);
        for (int i = 0; i < 65540; i++) begin
            tick();
        end
        drv1(1'b0, 1'b0, 32'h0);
        #1;
        chk("t8_cnt1_sat", pkt_cnt1, 16'hFFFF);
        chk("t8_cnt0", pkt_cnt0, 16'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/axis_tx_pkt_arbiter.md
# axis_tx_pkt_arbiter

Packet-aware two-source arbiter that shares the single PCIe SS TX AXI-S port between the MMIO read-completion stream (source 0) and the MSI-X interrupt stream (source 1). It sits between the MMIO and MSI-X TX bridges and the host-facing TX interface, replacing fixed-priority combinational muxing. It holds the grant for a whole packet, applies aging-based starvation relief to source 1, and keeps per-source packet statistics.

## Interface
- DATA_WIDTH, 512: tdata width in bits; tkeep width is DATA_WIDTH/8.
- USER_WIDTH, 10: tuser_vendor width in bits.
- MAX_HI_PKTS, 4: consecutive source-0 packets allowed while source 1 waits; 0 = strict priority, aging disabled. Range 0..255.

- clk  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- s0_tvalid / s0_tready / s0_tlast  in/out/in  1  source 0 (MMIO completions) handshake.
- s0_tdata / s0_tkeep / s0_tuser_vendor  in  DATA_WIDTH / DATA_WIDTH/8 / USER_WIDTH  source 0 payload.
- s1_*  same set as s0_*  source 1 (MSI-X).
- m_tvalid / m_tready / m_tlast  out/in/out  1  TX output handshake.
- m_tdata / m_tkeep / m_tuser_vendor  out  as above  output payload.
- stat_clr  in  1  single-cycle pulse; clears both packet counters.
- pkt_cnt0, pkt_cnt1  out  16  packets forwarded per source, saturating.
- busy  out  1  high while state is LOCK0 or LOCK1.

## Operation
- States: IDLE, LOCK0, LOCK1. Reset -> IDLE.
- IDLE: winner is chosen combinationally each cycle.
  - Only one sN_tvalid -> that source.
  - Both valid -> source 1 if MAX_HI_PKTS != 0 and hi_cnt == MAX_HI_PKTS, else source 0.
  - Winner's beat and handshake are forwarded in the same cycle. Loser's tready = 0.
  - Accepted beat with tlast=0 -> LOCKn. Accepted beat with tlast=1 -> stay in IDLE (single-beat packet).
- LOCKn: only source n is connected; other source's tready = 0. Source n dropping tvalid mid-packet drives m_tvalid=0 and keeps the lock. Accepted beat with tlast=1 -> IDLE.
- hi_cnt (8-bit):
  - On a source-0 packet completion (tlast handshake) while s1_tvalid=1: +1, saturating at MAX_HI_PKTS.
  - On a source-1 packet completion: cleared to 0.
  - Otherwise unchanged.
- pkt_cntN: +1 on each source-N tlast handshake, saturating at 0xFFFF.
  - stat_clr has priority over a same-cycle increment; the counter reads 0 the next cycle.
- Unselected source: payload is ignored, and m_* payload shows only the selected source.
- When no source is selected, m_tdata/m_tkeep/m_tuser_vendor/m_tlast are driven to 0.

## Timing
- Reset values: state IDLE, hi_cnt 0, pkt_cnt0/1 0, busy 0, m_tvalid 0, s0_tready 0, s1_tready 0.
- While rst=1, all tready and m_tvalid are forced to 0.
- Without output register: zero-cycle latency, sN_tready = m_tready for the selected source.
  - Back-to-back packets run with no bubble. The cycle after a tlast handshake, IDLE re-arbitrates and may forward a new first beat.
- State, hi_cnt and counters update on the clk edge after the qualifying handshake. busy rises the cycle after a non-last first beat.
- Grant never switches mid-packet, whatever the valid pattern or aging state.
- Reset mid-packet: returns to IDLE. A partial packet is not completed. Upstream sources are reset by the same rst.

## Configuration
- AXIS_TX_ARB_OUTREG_EN defined: outputs come from a 2-entry skid buffer.
  - Adds exactly 1 cycle of latency.
  - sN_tready is registered and means "buffer has a free entry", independent of the same-cycle m_tready.
  - Full throughput is sustained when m_tready=1.
  - Buffer is emptied by rst. m_tvalid resets to 0.
  - Arbitration, state and counters are driven by the input-side handshake.
- Not defined: the combinational pass-through described above.

## Test plan
- Source 0 only, 3 single-beat packets with m_tready=1 -> 3 consecutive output beats with no bubble; pkt_cnt0=3, pkt_cnt1=0.
- Source 0 4-beat packet; source 1 raises valid on beat 2 -> all 4 source-0 beats are contiguous, then the source-1 packet; s1_tready=0 throughout the source-0 packet; busy high on beats 2-4.
- MAX_HI_PKTS=4, both sources continuously valid with single-beat packets -> output order 0,0,0,0,1,0,0,0,0,1; hi_cnt returns to 0 after each source-1 packet.
- MAX_HI_PKTS=0, both sources continuously valid -> source 1 gets no grant until s0_tvalid drops.
- m_tready toggling 1/0 and source 0 dropping tvalid mid-packet -> no beat lost or duplicated; m_tvalid follows s0_tvalid; lock is held.
- Saturation and clear: 65540 source-1 packets -> pkt_cnt1=0xFFFF. stat_clr coincident with a tlast handshake -> 0 next cycle. Assert rst in LOCK1 -> IDLE, busy=0, m_tvalid=0 next cycle.
